// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the multi-channel pulse generator:
// per-channel FSM state encoding and the miss counter width.
package pulse_gen_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      ACTIVE = 2'd2
   } pg_state_t;

   // Width of each channel's ignored-trigger counter (saturates at all-ones).
   localparam int MISS_CNT_W = 8;

endpackage

// File: rtl/pulse_gen_ch.sv
// Single pulse generator channel: IDLE/DELAY/ACTIVE FSM, delay/width counting,
// width latch, sticky missed flag and the optional saturating miss counter
// (enabled by defining PULSE_GEN_MISS_CNT_EN).
module pulse_gen_ch
   import pulse_gen_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_trg,
   input  logic                  i_retrig,
   input  logic [CNT_W-1:0]      i_dly,
   input  logic [CNT_W-1:0]      i_wid,
   input  logic                  i_miss_clr,
   output logic                  o_pulse,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_missed,
   output logic [MISS_CNT_W-1:0] o_miss_cnt
);

   pg_state_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_wid;
   logic             r_pulse;
   logic             r_busy;
   logic             r_done;
   logic             r_missed;

   logic             w_start;
   logic             w_miss;

   // A trigger (re)starts the channel when idle, or when busy in retrigger mode;
   // otherwise a trigger while busy is a miss. The final pulse cycle is busy.
   assign w_start = i_trg && ((r_state == IDLE) || i_retrig);
   assign w_miss  = i_trg && (r_state != IDLE) && !i_retrig;

   // Channel FSM: r_cnt holds the cycles remaining in the current phase,
   // including the present one, so a phase ends when r_cnt reaches 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_wid   <= '0;
         r_pulse <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_start) begin
            // Start (or restart) exactly as from IDLE; an aborted pulse gets no done.
            r_wid <= i_wid;
            if (i_wid == '0) begin
               r_state <= IDLE;
               r_cnt   <= '0;
               r_pulse <= 1'b0;
               r_busy  <= 1'b0;
            end else if (i_dly == '0) begin
               r_state <= ACTIVE;
               r_cnt   <= i_wid;
               r_pulse <= 1'b1;
               r_busy  <= 1'b1;
            end else begin
               r_state <= DELAY;
               r_cnt   <= i_dly;
               r_pulse <= 1'b0;
               r_busy  <= 1'b1;
            end
         end else begin
            case (r_state)
               DELAY: begin
                  if (r_cnt == CNT_W'(1)) begin
                     r_state <= ACTIVE;
                     r_cnt   <= r_wid;
                     r_pulse <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt - CNT_W'(1);
                  end
               end
               ACTIVE: begin
                  if (r_cnt == CNT_W'(1)) begin
                     r_state <= IDLE;
                     r_cnt   <= '0;
                     r_pulse <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt - CNT_W'(1);
                  end
               end
               default: begin
                  r_state <= IDLE;
                  r_pulse <= 1'b0;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   // Sticky missed flag; a new miss wins over a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_missed <= 1'b0;
      end else if (w_miss) begin
         r_missed <= 1'b1;
      end else if (i_miss_clr) begin
         r_missed <= 1'b0;
      end
   end

`ifdef PULSE_GEN_MISS_CNT_EN
   logic [MISS_CNT_W-1:0] r_miss_cnt;

   // Saturating miss counter; clear with a simultaneous miss leaves a count of 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_miss_cnt <= '0;
      end else if (i_miss_clr) begin
         r_miss_cnt <= w_miss ? MISS_CNT_W'(1) : '0;
      end else if (w_miss && (r_miss_cnt != '1)) begin
         r_miss_cnt <= r_miss_cnt + MISS_CNT_W'(1);
      end
   end

   assign o_miss_cnt = r_miss_cnt;
`else
   assign o_miss_cnt = '0;
`endif

   assign o_pulse  = r_pulse;
   assign o_busy   = r_busy;
   assign o_done   = r_done;
   assign o_missed = r_missed;

endmodule

// File: rtl/pulse_gen_mc.sv
// Multi-channel programmable pulse generator top: qualifies strobes with the
// global enable and slices the packed per-channel buses onto CH independent
// pulse_gen_ch instances. Optional per-channel miss counters are built when
// PULSE_GEN_MISS_CNT_EN is defined; otherwise miss_cnt reads as zero.
module pulse_gen_mc
   import pulse_gen_pkg::*;
#(
   parameter int CH    = 4,
   parameter int CNT_W = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ena,
   input  logic [CH-1:0]              str,
   input  logic [CH-1:0]              retrig,
   input  logic [CH*CNT_W-1:0]        dly,
   input  logic [CH*CNT_W-1:0]        wid,
   output logic [CH-1:0]              pulseo,
   output logic [CH-1:0]              busy,
   output logic [CH-1:0]              done,
   output logic [CH-1:0]              missed,
   input  logic                       miss_clr,
   output logic [CH*MISS_CNT_W-1:0]   miss_cnt
);

   logic [CH-1:0] w_trg;

   // The global enable only gates new triggers; pulses in flight keep running.
   assign w_trg = str & {CH{ena}};

   genvar gi;
   generate
      for (gi = 0; gi < CH; gi++) begin : g_ch
         pulse_gen_ch #(
            .CNT_W (CNT_W)
         ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .i_trg      (w_trg[gi]),
            .i_retrig   (retrig[gi]),
            .i_dly      (dly[gi*CNT_W +: CNT_W]),
            .i_wid      (wid[gi*CNT_W +: CNT_W]),
            .i_miss_clr (miss_clr),
            .o_pulse    (pulseo[gi]),
            .o_busy     (busy[gi]),
            .o_done     (done[gi]),
            .o_missed   (missed[gi]),
            .o_miss_cnt (miss_cnt[gi*MISS_CNT_W +: MISS_CNT_W])
         );
      end
   endgenerate

endmodule

// File: tb/tb_pulse_gen_mc.sv
// Directed testbench for pulse_gen_mc. Expected per-cycle pulseo/busy/done
// vectors are derived from the timing formulas and queued when a trigger is
// driven, then popped and compared one cycle at a time.
module tb_pulse_gen_mc;
   localparam int CH    = 4;
   localparam int CNT_W = 8;

   logic                clk = 1'b0;
   logic                rst;
   logic                ena;
   logic [CH-1:0]       str;
   logic [CH-1:0]       retrig;
   logic [CH*CNT_W-1:0] dly;
   logic [CH*CNT_W-1:0] wid;
   logic [CH-1:0]       pulseo;
   logic [CH-1:0]       busy;
   logic [CH-1:0]       done;
   logic [CH-1:0]       missed;
   logic                miss_clr;
   logic [CH*8-1:0]     miss_cnt;

   pulse_gen_mc #(.CH(CH), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .str      (str),
      .retrig   (retrig),
      .dly      (dly),
      .wid      (wid),
      .pulseo   (pulseo),
      .busy     (busy),
      .done     (done),
      .missed   (missed),
      .miss_clr (miss_clr),
      .miss_cnt (miss_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string         tag;
      logic [CH-1:0] p;
      logic [CH-1:0] b;
      logic [CH-1:0] d;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge and compare one queued cycle.
   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk({e.tag, "/pulseo"}, 64'(pulseo), 64'(e.p));
         chk({e.tag, "/busy"},   64'(busy),   64'(e.b));
         chk({e.tag, "/done"},   64'(done),   64'(e.d));
      end
   endtask

   task automatic set_ch(input int ch, input int d, input int w, input bit rt);
      dly[ch*CNT_W +: CNT_W] = CNT_W'(d);
      wid[ch*CNT_W +: CNT_W] = CNT_W'(w);
      retrig[ch] = rt;
   endtask

   task automatic push_e(input string tag, input logic [CH-1:0] p,
                         input logic [CH-1:0] b, input logic [CH-1:0] d);
      exp_t e;
      e.tag = tag; e.p = p; e.b = b; e.d = d;
      sb_q.push_back(e);
   endtask

   // Expected cycles t+1..t+ncyc for a trigger at t on the channels in mask:
   // busy t+1..t+D+W, pulse t+D+1..t+D+W, done at t+D+W+1; nothing when W=0.
   task automatic push_window(input string tag, input logic [CH-1:0] mask,
                              input int d, input int w, input int ncyc);
      logic [CH-1:0] p, b, dn;
      for (int k = 1; k <= ncyc; k++) begin
         p  = (w > 0 && k >= d + 1 && k <= d + w) ? mask : '0;
         b  = (w > 0 && k <= d + w) ? mask : '0;
         dn = (w > 0 && k == d + w + 1) ? mask : '0;
         push_e(tag, p, b, dn);
      end
   endtask

   logic [CH*8-1:0] exp_mc;

   initial begin
      rst = 1'b1; ena = 1'b0; str = '0; retrig = '0;
      dly = '0; wid = '0; miss_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset/pulseo",   64'(pulseo),   64'(0));
      chk("reset/busy",     64'(busy),     64'(0));
      chk("reset/done",     64'(done),     64'(0));
      chk("reset/missed",   64'(missed),   64'(0));
      chk("reset/miss_cnt", 64'(miss_cnt), 64'(0));
      rst = 1'b0; ena = 1'b1;
      step();

      // ch0, D=0 W=3
      set_ch(0, 0, 3, 1'b0); str[0] = 1'b1;
      push_window("t1_d0w3", 4'b0001, 0, 3, 6);
      step(); str[0] = 1'b0;
      repeat (5) step();
      $display("t1 ch0 D=0 W=3 done, misc=%0d", n_err);

      // ch1, D=2 W=1, retrig=0, second strobe at t+2; inputs changed after latch
      set_ch(1, 2, 1, 1'b0); str[1] = 1'b1;
      push_window("t2_d2w1", 4'b0010, 2, 1, 6);
      step(); str[1] = 1'b0; set_ch(1, 0, 9, 1'b0);
      step(); str[1] = 1'b1;
      step(); str[1] = 1'b0;
      chk("t2/missed", 64'(missed), 64'(4'b0010));
`ifdef PULSE_GEN_MISS_CNT_EN
      exp_mc = 32'h0000_0100;
`else
      exp_mc = '0;
`endif
      chk("t2/miss_cnt", 64'(miss_cnt), 64'(exp_mc));
      repeat (3) step();
      miss_clr = 1'b1; step(); miss_clr = 1'b0;
      chk("t2_clr/missed",   64'(missed),   64'(0));
      chk("t2_clr/miss_cnt", 64'(miss_cnt), 64'(0));
      $display("t2 ch1 D=2 W=1 miss done, misc=%0d", n_err);

      // ch2 retrigger D=0 W=4, re-strobe at t+2 -> continuous pulse t+1..t+6
      set_ch(2, 0, 4, 1'b1); str[2] = 1'b1;
      for (int k = 1; k <= 6; k++) push_e("t3_retrig", 4'b0100, 4'b0100, 4'b0000);
      push_e("t3_retrig", 4'b0000, 4'b0000, 4'b0100);
      push_e("t3_retrig", 4'b0000, 4'b0000, 4'b0000);
      step(); str[2] = 1'b0;
      step(); str[2] = 1'b1;
      step(); str[2] = 1'b0;
      repeat (5) step();
      chk("t3/missed", 64'(missed), 64'(0));
      $display("t3 ch2 retrig continuous done, misc=%0d", n_err);

      // W=0 on ch3, then strobe ch0 with ena=0: nothing happens
      set_ch(3, 5, 0, 1'b0); str[3] = 1'b1;
      push_window("t4_null", 4'b1000, 5, 0, 4);
      step(); str[3] = 1'b0; ena = 1'b0; set_ch(0, 0, 3, 1'b0); str[0] = 1'b1;
      step(); str[0] = 1'b0; ena = 1'b1;
      repeat (2) step();
      chk("t4/missed", 64'(missed), 64'(0));
      $display("t4 W=0 and ena=0 done, misc=%0d", n_err);

      // ch0 retrigger with W=0 while ACTIVE aborts: low at t+3, no done
      set_ch(0, 0, 5, 1'b1); str[0] = 1'b1;
      push_e("t5_abort", 4'b0001, 4'b0001, 4'b0000);
      push_e("t5_abort", 4'b0001, 4'b0001, 4'b0000);
      for (int k = 3; k <= 5; k++) push_e("t5_abort", 4'b0000, 4'b0000, 4'b0000);
      step(); str[0] = 1'b0;
      step(); set_ch(0, 0, 0, 1'b1); str[0] = 1'b1;
      step(); str[0] = 1'b0;
      repeat (2) step();
      $display("t5 retrig W=0 abort done, misc=%0d", n_err);

      // ch3 retrig=0 D=0 W=3; misses at t+1 and on final pulse cycle with clear
      set_ch(3, 0, 3, 1'b0); str[3] = 1'b1;
      push_window("t6_final", 4'b1000, 0, 3, 5);
      step(); str[3] = 1'b1;
      step(); str[3] = 1'b0;
      chk("t6/missed1", 64'(missed), 64'(4'b1000));
`ifdef PULSE_GEN_MISS_CNT_EN
      exp_mc = 32'h0100_0000;
`else
      exp_mc = '0;
`endif
      chk("t6/miss_cnt1", 64'(miss_cnt), 64'(exp_mc));
      step(); str[3] = 1'b1; miss_clr = 1'b1;
      step(); str[3] = 1'b0; miss_clr = 1'b0;
      chk("t6/missed2", 64'(missed), 64'(4'b1000));
      chk("t6/miss_cnt2", 64'(miss_cnt), 64'(exp_mc));
      step();
      miss_clr = 1'b1; step(); miss_clr = 1'b0;
      chk("t6_clr/missed", 64'(missed), 64'(0));
      $display("t6 final-cycle miss and clear/set done, misc=%0d", n_err);

      // ch2 ACTIVE retriggered with D=2 W=1: pulse drops during the new delay
      set_ch(2, 0, 4, 1'b1); str[2] = 1'b1;
      push_e("t7_redelay", 4'b0100, 4'b0100, 4'b0000);
      push_e("t7_redelay", 4'b0100, 4'b0100, 4'b0000);
      push_e("t7_redelay", 4'b0000, 4'b0100, 4'b0000);
      push_e("t7_redelay", 4'b0000, 4'b0100, 4'b0000);
      push_e("t7_redelay", 4'b0100, 4'b0100, 4'b0000);
      push_e("t7_redelay", 4'b0000, 4'b0000, 4'b0100);
      push_e("t7_redelay", 4'b0000, 4'b0000, 4'b0000);
      step(); str[2] = 1'b0;
      step(); set_ch(2, 2, 1, 1'b1); str[2] = 1'b1;
      step(); str[2] = 1'b0;
      repeat (4) step();
      $display("t7 retrig active->delay done, misc=%0d", n_err);

      // all channels at once, D=1 W=2
      for (int c = 0; c < CH; c++) set_ch(c, 1, 2, 1'b0);
      str = '1;
      push_window("t8_all", 4'b1111, 1, 2, 5);
      step(); str = '0;
      repeat (4) step();
      $display("t8 simultaneous channels done, misc=%0d", n_err);

      // ch1 maximum D=255 W=255: pulse t+256..t+510, done t+511
      set_ch(1, 255, 255, 1'b0); str[1] = 1'b1;
      push_window("t9_max", 4'b0010, 255, 255, 513);
      step(); str[1] = 1'b0;
      repeat (512) step();
      $display("t9 max D/W done, misc=%0d", n_err);

`ifdef PULSE_GEN_MISS_CNT_EN
      // miss counter saturation: 300 ignored strobes during a long pulse
      set_ch(0, 255, 255, 1'b0); str[0] = 1'b1;
      step();
      repeat (300) step();
      str[0] = 1'b0;
      step();
      chk("t10/miss_cnt_sat", 64'(miss_cnt), 64'(32'h0000_00FF));
      repeat (220) step();
      chk("t10/busy_end", 64'(busy), 64'(0));
      miss_clr = 1'b1; step(); miss_clr = 1'b0;
      chk("t10_clr/miss_cnt", 64'(miss_cnt), 64'(0));
      $display("t10 miss counter saturation done, misc=%0d", n_err);
`endif

      // asynchronous reset during ACTIVE, then a fresh trigger
      set_ch(0, 0, 10, 1'b0); str[0] = 1'b1;
      step(); str[0] = 1'b0;
      step();
      chk("t11/pulse_before", 64'(pulseo), 64'(4'b0001));
      #2 rst = 1'b1;
      #1;
      chk("t11/pulseo_rst", 64'(pulseo), 64'(0));
      chk("t11/busy_rst",   64'(busy),   64'(0));
      chk("t11/done_rst",   64'(done),   64'(0));
      #3 rst = 1'b0;
      step();
      chk("t11/done_after", 64'(done), 64'(0));
      set_ch(0, 1, 2, 1'b0); str[0] = 1'b1;
      push_window("t11_after", 4'b0001, 1, 2, 5);
      step(); str[0] = 1'b0;
      repeat (4) step();
      $display("t11 reset mid-pulse done, misc=%0d", n_err);

      chk("sb_empty", 64'(sb_q.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
